// File: rtl/mul_accumulator_unsigned.sv
// rtl/mul_accumulator_unsigned.sv - dot-product accumulator stage behind multiplier_unsigned
//
// Sums the unsigned product stream from multiplier_unsigned into one result per vector.
// Each vector ends on a last-term marker. The upstream valid/last pair is delayed by
// MUL_LATENCY stages so that it lines up with the matching product on p. Each finished
// vector is presented on a single valid/ready output register.
//
// Parameters
//   BITWIDTH_INPUT  operand width of the upstream multiplier (product is 2*BITWIDTH_INPUT)
//   MUL_LATENCY     multiplier pipeline depth, 1..16
//   ACC_GUARD_BITS  extra accumulator MSBs; ACC_W = 2*BITWIDTH_INPUT + ACC_GUARD_BITS
//   BITWIDTH_LEN    width of the term counter
//
// Ports
//   clk           in   rising-edge clock
//   rstn          in   asynchronous active-low reset
//   in_valid      in   a/b presented to the multiplier this cycle form a valid term
//   in_last       in   with in_valid: this term closes the vector
//   p             in   product q from multiplier_unsigned
//   out_valid     out  out_sum/out_count/out_overflow hold a finished vector
//   out_ready     in   consumer takes the result when out_valid && out_ready
//   out_sum       out  accumulated sum of the vector
//   out_count     out  number of terms in the vector, saturating at all-ones
//   out_overflow  out  the sum carried out of ACC_W bits during the vector
//   drop_err      out  sticky: a finished vector was discarded because the output was held
//
// Configuration
//   MUL_ACC_SATURATE_EN  defined: the accumulator clamps to all-ones on overflow.
//                        undefined: the accumulator wraps modulo 2^ACC_W.

module mul_accumulator_unsigned #(
  parameter int BITWIDTH_INPUT = 32,
  parameter int MUL_LATENCY    = 2,
  parameter int ACC_GUARD_BITS = 8,
  parameter int BITWIDTH_LEN   = 16,
  localparam int PROD_W        = 2 * BITWIDTH_INPUT,
  localparam int ACC_W         = PROD_W + ACC_GUARD_BITS
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    in_valid,
  input  logic                    in_last,
  input  logic [PROD_W-1:0]       p,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ACC_W-1:0]        out_sum,
  output logic [BITWIDTH_LEN-1:0] out_count,
  output logic                    out_overflow,
  output logic                    drop_err
);

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  // Delay line: stage 0 captures the term marker on the same edge the multiplier samples
  // a/b, so the last stage is valid on the cycle its product appears on p.
  logic [MUL_LATENCY-1:0] dly_valid;
  logic [MUL_LATENCY-1:0] dly_last;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dly_valid <= '0;
      dly_last  <= '0;
    end else begin
      dly_valid[0] <= in_valid;
      dly_last[0]  <= in_valid & in_last;
      for (int i = 1; i < MUL_LATENCY; i++) begin
        dly_valid[i] <= dly_valid[i-1];
        dly_last[i]  <= dly_last[i-1];
      end
    end
  end

  logic d_valid;
  logic d_last;

  assign d_valid = dly_valid[MUL_LATENCY-1];
  assign d_last  = dly_last[MUL_LATENCY-1];

  // Accumulation state
  state_t                  state;
  logic [ACC_W-1:0]        acc;
  logic [BITWIDTH_LEN-1:0] count;
  logic                    ovf;

  // Next values for the current term; used both to continue a vector and as the
  // finished result when the term is the last one.
  logic [ACC_W:0]          sum_ext;
  logic                    carry;
  logic [ACC_W-1:0]        acc_base;
  logic [ACC_W-1:0]        acc_next;
  logic                    ovf_next;
  logic [BITWIDTH_LEN-1:0] count_next;

  always_comb begin
    acc_base = (state == ACCUM) ? acc : '0;
    sum_ext  = {1'b0, acc_base} + {{(ACC_GUARD_BITS + 1){1'b0}}, p};
    carry    = sum_ext[ACC_W];
`ifdef MUL_ACC_SATURATE_EN
    // Once clamped, acc is all-ones; any further non-zero product carries again and
    // re-clamps, so the value stays pinned until the vector ends.
    acc_next = carry ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
    acc_next = sum_ext[ACC_W-1:0];
`endif
    ovf_next = ((state == ACCUM) & ovf) | carry;
    if (state == IDLE) begin
      count_next = BITWIDTH_LEN'(1);
    end else if (&count) begin
      count_next = count;
    end else begin
      count_next = count + BITWIDTH_LEN'(1);
    end
  end

  // Output register handshake
  logic finish;
  logic pop;
  logic load;
  logic drop;

  assign finish = d_valid & d_last;
  assign pop    = out_valid & out_ready;
  // A finishing vector can take the register when it is empty or being emptied now.
  assign load   = finish & (~out_valid | out_ready);
  // The multiplier cannot stall, so a result with nowhere to go is lost.
  assign drop   = finish & out_valid & ~out_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      acc          <= '0;
      count        <= '0;
      ovf          <= 1'b0;
      out_valid    <= 1'b0;
      out_sum      <= '0;
      out_count    <= '0;
      out_overflow <= 1'b0;
      drop_err     <= 1'b0;
    end else begin
      if (d_valid) begin
        if (d_last) begin
          state <= IDLE;
          acc   <= '0;
          count <= '0;
          ovf   <= 1'b0;
        end else begin
          state <= ACCUM;
          acc   <= acc_next;
          count <= count_next;
          ovf   <= ovf_next;
        end
      end

      if (load) begin
        out_valid    <= 1'b1;
        out_sum      <= acc_next;
        out_count    <= count_next;
        out_overflow <= ovf_next;
      end else if (pop) begin
        out_valid    <= 1'b0;
        out_sum      <= '0;
        out_count    <= '0;
        out_overflow <= 1'b0;
      end

      if (drop) begin
        drop_err <= 1'b1;
      end
    end
  end

endmodule
